// File: rtl/fdtd_pkg.sv
// fdtd_pkg: shared FSM states, field-select constants and the saturating fixed-point MAC
package fdtd_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_SRC, UPD_H, UPD_E, INJECT, SAMPLE} state_t;
  localparam logic HY = 1'b0;
  localparam logic EZ = 1'b1;
  function automatic logic signed [63:0] sat_mac(input logic signed [63:0] a, x, b, d, input int frac_w, data_w);
    logic signed [127:0] s, hi, lo;
    s = (128'(a) * 128'(x) + 128'(b) * 128'(d)) >>> frac_w;
    hi = (128'sd1 <<< (data_w - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
    return s > hi ? 64'(hi) : s < lo ? 64'(lo) : 64'(s);
  endfunction
endpackage

// File: rtl/fdtd_1d_engine_if.sv
// fdtd_1d_engine_if: source handshake, field load and readback bus
interface fdtd_1d_engine_if #(parameter int DATA_W = 32, parameter int ADDR_W = 8);
  logic              jz_valid_i, jz_ready_o;
  logic [DATA_W-1:0] jz_i;
  logic              ld_en_i, ld_sel_i;
  logic [ADDR_W-1:0] ld_addr_i;
  logic [DATA_W-1:0] ld_data_i;
  logic              rd_en_i, rd_sel_i, rd_valid_o;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [DATA_W-1:0] rd_data_o;
  modport master (output jz_valid_i, jz_i, ld_en_i, ld_sel_i, ld_addr_i, ld_data_i, rd_en_i, rd_sel_i, rd_addr_i,
                  input jz_ready_o, rd_data_o, rd_valid_o);
  modport slave (input jz_valid_i, jz_i, ld_en_i, ld_sel_i, ld_addr_i, ld_data_i, rd_en_i, rd_sel_i, rd_addr_i,
                 output jz_ready_o, rd_data_o, rd_valid_o);
endinterface

// File: rtl/fdtd_field_ram.sv
// fdtd_field_ram: one field array, single write port, two combinational read ports
module fdtd_field_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  // field storage is deliberately left unreset so loaded data survives a reset
  always_ff @(posedge clk) if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];
endmodule

// File: rtl/fdtd_1d_engine.sv
// fdtd_1d_engine: sequential 1-D Yee leapfrog solver over Hy/Ez field RAMs
module fdtd_1d_engine import fdtd_pkg::*; #(
  parameter int DATA_W    = 32,
  parameter int FRAC_W    = 16,
  parameter int MAX_CELLS = 256,
  parameter int STEP_W    = 16,
  localparam int ADDR_W   = $clog2(MAX_CELLS)
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic signed [DATA_W-1:0] ceze_i, cezhy_i, cezj_i, chyh_i, chyez_i,
  input  logic [ADDR_W:0]          n_cells_i,
  input  logic [STEP_W-1:0]        n_steps_i,
  input  logic [ADDR_W-1:0]        src_idx_i, probe_idx_i,
  input  logic                     start_i, abort_i,
  input  logic                     int_en_i, int_clr_i,
  output logic                     busy_o, done_o,
  output logic [STEP_W-1:0]        step_cnt_o,
  output logic [DATA_W-1:0]        sample_o,
  output logic                     sample_valid_o,
  output logic                     int_o,
  fdtd_1d_engine_if.slave          bus
);
  localparam logic signed [DATA_W-1:0] ONE = DATA_W'(64'sd1 <<< FRAC_W);
  state_t state_q, state_d;
  logic signed [DATA_W-1:0] ceze_q, cezhy_q, cezj_q, chyh_q, chyez_q, jz_q;
  logic [ADDR_W:0] n_q;
  logic [STEP_W-1:0] steps_q, step_cnt_q;
  logic [ADDR_W-1:0] src_q, probe_q, m_q;
  logic done_q, sample_valid_q, rd_valid_q, int_q;
  logic [DATA_W-1:0] sample_q, rd_data_q;
  logic signed [DATA_W-1:0] hy_ra, hy_rb, ez_ra, ez_rb, hy_wd, ez_wd;
  logic [ADDR_W-1:0] hy_wa, ez_wa, hy_raa, ez_raa;
  logic hy_we, ez_we, idle_ld, start_ok, h_last, e_last, s_last, src_ok, probe_ok, live;
  logic signed [DATA_W:0] ez_diff, hy_diff;
  assign start_ok = start_i & (n_cells_i >= (ADDR_W+1)'(2)) & (n_steps_i != '0);
  assign h_last   = m_q == ADDR_W'(n_q - (ADDR_W+1)'(2));
  assign e_last   = m_q == ADDR_W'(n_q - (ADDR_W+1)'(1));
  assign s_last   = STEP_W'(step_cnt_q + STEP_W'(1)) == steps_q;
  assign src_ok   = (ADDR_W+1)'(src_q) < n_q;
  assign probe_ok = (ADDR_W+1)'(probe_q) < n_q;
  assign live     = !abort_i;
  assign ez_diff  = (DATA_W+1)'(ez_rb) - (DATA_W+1)'(ez_ra);
  assign hy_diff  = (DATA_W+1)'(hy_ra) - (DATA_W+1)'(hy_rb);
  // state register
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) state_q <= IDLE;
    else state_q <= state_d;
  // next-state: abort from any busy state returns straight to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = start_ok ? WAIT_SRC : IDLE;
      WAIT_SRC: state_d = bus.jz_valid_i ? UPD_H : WAIT_SRC;
      UPD_H:    state_d = h_last ? UPD_E : UPD_H;
      UPD_E:    state_d = e_last ? INJECT : UPD_E;
      INJECT:   state_d = SAMPLE;
      SAMPLE:   state_d = s_last ? IDLE : WAIT_SRC;
      default:  state_d = IDLE;
    endcase
    if (abort_i && state_q != IDLE) state_d = IDLE;
  end
  // outputs: RAM addressing and write enables per state, loads only while idle
  always_comb begin
    idle_ld = state_q == IDLE && bus.ld_en_i;
    busy_o  = state_q != IDLE;
    bus.jz_ready_o = state_q == WAIT_SRC && live;
    hy_we   = (idle_ld && bus.ld_sel_i == HY) || (state_q == UPD_H && live);
    ez_we   = (idle_ld && bus.ld_sel_i == EZ) || ((state_q == UPD_E || (state_q == INJECT && src_ok)) && live);
    hy_wa   = state_q == IDLE ? bus.ld_addr_i : m_q;
    ez_wa   = state_q == IDLE ? bus.ld_addr_i : state_q == INJECT ? src_q : m_q;
    hy_raa  = state_q == IDLE ? bus.rd_addr_i : m_q;
    ez_raa  = state_q == IDLE ? bus.rd_addr_i : state_q == INJECT ? src_q : state_q == SAMPLE ? probe_q : m_q;
    hy_wd   = state_q == IDLE ? bus.ld_data_i :
              DATA_W'(sat_mac(64'(chyh_q), 64'(hy_ra), 64'(chyez_q), 64'(ez_diff), FRAC_W, DATA_W));
    ez_wd   = state_q == IDLE ? bus.ld_data_i :
              state_q == INJECT ? DATA_W'(sat_mac(64'(ONE), 64'(ez_ra), 64'(cezj_q), 64'(jz_q), FRAC_W, DATA_W)) :
              DATA_W'(sat_mac(64'(ceze_q), 64'(ez_ra), 64'(cezhy_q), 64'(hy_diff), FRAC_W, DATA_W));
  end
  // datapath: config latch, cell index, step count, probe, readback and interrupt
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      {ceze_q, cezhy_q, cezj_q, chyh_q, chyez_q, jz_q} <= '0;
      {n_q, steps_q, src_q, probe_q, m_q, step_cnt_q} <= '0;
      {done_q, sample_valid_q, rd_valid_q, int_q, sample_q, rd_data_q} <= '0;
    end else begin
      done_q         <= (state_q == IDLE && start_i && !start_ok) || (state_q == SAMPLE && live && s_last);
      sample_valid_q <= state_q == SAMPLE && live;
      rd_valid_q     <= bus.rd_en_i;
      int_q          <= (done_q && int_en_i) || (int_q && !int_clr_i);
      if (bus.rd_en_i) rd_data_q <= busy_o ? '0 : bus.rd_sel_i == EZ ? ez_ra : hy_ra;
      if (state_q == SAMPLE && live) sample_q <= probe_ok ? ez_ra : '0;
      if (state_q == SAMPLE && live) step_cnt_q <= step_cnt_q + STEP_W'(1);
      if (state_q == IDLE && start_ok) begin
        {ceze_q, cezhy_q, cezj_q, chyh_q, chyez_q} <= {ceze_i, cezhy_i, cezj_i, chyh_i, chyez_i};
        {n_q, steps_q, src_q, probe_q} <= {n_cells_i, n_steps_i, src_idx_i, probe_idx_i};
        step_cnt_q <= '0;
      end
      if (state_q == WAIT_SRC && bus.jz_valid_i && live) begin
        jz_q <= bus.jz_i;
        m_q  <= '0;
      end
      if (state_q == UPD_H) m_q <= h_last ? ADDR_W'(1) : m_q + ADDR_W'(1);
      if (state_q == UPD_E) m_q <= m_q + ADDR_W'(1);
    end
  assign done_o         = done_q;
  assign step_cnt_o     = step_cnt_q;
  assign sample_o       = sample_q;
  assign sample_valid_o = sample_valid_q;
  assign int_o          = int_q;
  assign bus.rd_data_o  = rd_data_q;
  assign bus.rd_valid_o = rd_valid_q;
  fdtd_field_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(MAX_CELLS)) u_hy (
    .clk(ACLK), .we_i(hy_we), .waddr_i(hy_wa), .wdata_i(hy_wd),
    .raddr_a_i(hy_raa), .raddr_b_i(m_q - ADDR_W'(1)), .rdata_a_o(hy_ra), .rdata_b_o(hy_rb)
  );
  fdtd_field_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(MAX_CELLS)) u_ez (
    .clk(ACLK), .we_i(ez_we), .waddr_i(ez_wa), .wdata_i(ez_wd),
    .raddr_a_i(ez_raa), .raddr_b_i(m_q + ADDR_W'(1)), .rdata_a_o(ez_ra), .rdata_b_o(ez_rb)
  );
endmodule

// File: tb/tb_fdtd_1d_engine.sv
// tb_fdtd_1d_engine: directed vectors with a queue scoreboard on readback and probe outputs
module tb_fdtd_1d_engine;
  import fdtd_pkg::*;
  localparam logic [31:0] ONE = 32'h0001_0000;
  logic ACLK = 0, ARESETn = 0;
  logic [31:0] ceze_i, cezhy_i, cezj_i, chyh_i, chyez_i;
  logic [8:0] n_cells_i;
  logic [15:0] n_steps_i, step_cnt_o;
  logic [7:0] src_idx_i, probe_idx_i;
  logic start_i, abort_i, int_en_i, int_clr_i, busy_o, done_o, sample_valid_o, int_o;
  logic [31:0] sample_o;
  typedef struct { string name; logic [31:0] v; } exp_t;
  exp_t rd_exp[$], smp_exp[$];
  int tests = 0, fails = 0, cyc;
  fdtd_1d_engine_if #(.DATA_W(32), .ADDR_W(8)) bus ();
  fdtd_1d_engine dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .ceze_i(ceze_i), .cezhy_i(cezhy_i), .cezj_i(cezj_i),
    .chyh_i(chyh_i), .chyez_i(chyez_i), .n_cells_i(n_cells_i), .n_steps_i(n_steps_i),
    .src_idx_i(src_idx_i), .probe_idx_i(probe_idx_i), .start_i(start_i), .abort_i(abort_i),
    .int_en_i(int_en_i), .int_clr_i(int_clr_i), .busy_o(busy_o), .done_o(done_o),
    .step_cnt_o(step_cnt_o), .sample_o(sample_o), .sample_valid_o(sample_valid_o),
    .int_o(int_o), .bus(bus)
  );
  always #5 ACLK = ~ACLK;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  // monitor: every readback or probe output must match the next expected entry
  always @(negedge ACLK) begin
    exp_t e;
    if (bus.rd_valid_o) begin
      if (rd_exp.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else begin e = rd_exp.pop_front(); chk(e.name, bus.rd_data_o, e.v); end
    end
    if (sample_valid_o) begin
      if (smp_exp.size() == 0) chk("sample_unexpected", 32'd1, 32'd0);
      else begin e = smp_exp.pop_front(); chk(e.name, sample_o, e.v); end
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic tick(); @(posedge ACLK); #1; endtask
  task automatic ld(input logic sel, input logic [7:0] a, input logic [31:0] d);
    bus.ld_en_i = 1; bus.ld_sel_i = sel; bus.ld_addr_i = a; bus.ld_data_i = d;
    tick();
    bus.ld_en_i = 0;
  endtask
  task automatic rd(input logic sel, input logic [7:0] a, input logic [31:0] e, input string n);
    rd_exp.push_back('{n, e});
    bus.rd_en_i = 1; bus.rd_sel_i = sel; bus.rd_addr_i = a;
    tick();
    bus.rd_en_i = 0;
  endtask
  task automatic cfg(input logic [31:0] ce, ch, cj, hh, he, input logic [8:0] n, input logic [15:0] s,
                     input logic [7:0] src, prb);
    ceze_i = ce; cezhy_i = ch; cezj_i = cj; chyh_i = hh; chyez_i = he;
    n_cells_i = n; n_steps_i = s; src_idx_i = src; probe_idx_i = prb;
  endtask
  task automatic run(); start_i = 1; tick(); start_i = 0; endtask
  task automatic wait_done(input int max, output int c);
    c = 0;
    do begin tick(); c++; end while (!done_o && c < max);
    if (!done_o) chk("done_timeout", 32'd0, 32'd1);
  endtask
  task automatic smp(input logic [31:0] v, input string n); smp_exp.push_back('{n, v}); endtask
  initial begin
    start_i = 0; abort_i = 0; int_en_i = 0; int_clr_i = 0;
    bus.jz_valid_i = 0; bus.jz_i = 0; bus.ld_en_i = 0; bus.ld_sel_i = 0; bus.ld_addr_i = 0;
    bus.ld_data_i = 0; bus.rd_en_i = 0; bus.rd_sel_i = 0; bus.rd_addr_i = 0;
    cfg(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_busy", 32'(busy_o), 0); chk("rst_done", 32'(done_o), 0);
    chk("rst_jz_ready", 32'(bus.jz_ready_o), 0); chk("rst_rd_valid", 32'(bus.rd_valid_o), 0);
    chk("rst_sample_valid", 32'(sample_valid_o), 0); chk("rst_int", 32'(int_o), 0);
    chk("rst_step_cnt", 32'(step_cnt_o), 0); chk("rst_sample", sample_o, 0);
    chk("rst_rd_data", bus.rd_data_o, 0);
    ARESETn = 1; tick();
    // unit coefficients, half-unit source for four steps
    for (int i = 0; i < 8; i++) begin ld(HY, 8'(i), 0); ld(EZ, 8'(i), 0); end
    cfg(ONE, 0, ONE, ONE, 0, 8, 4, 3, 3);
    bus.jz_i = 32'h0000_8000; bus.jz_valid_i = 1; int_en_i = 1;
    smp(32'h0000_8000, "t1_s1"); smp(32'h0001_0000, "t1_s2"); smp(32'h0001_8000, "t1_s3"); smp(32'h0002_0000, "t1_s4");
    run();
    wait_done(200, cyc);
    chk("t1_done_cycle", 32'(cyc), 68);
    int_clr_i = 1; tick();
    chk("t1_int_set_wins", 32'(int_o), 1); chk("t1_done_pulse", 32'(done_o), 0);
    tick();
    chk("t1_int_cleared", 32'(int_o), 0);
    int_clr_i = 0; int_en_i = 0;
    chk("t1_step_cnt", 32'(step_cnt_o), 4); chk("t1_busy", 32'(busy_o), 0);
    rd(EZ, 3, 32'h0002_0000, "t1_ez3"); rd(EZ, 2, 0, "t1_ez2"); rd(HY, 3, 0, "t1_hy3");
    // saturation on injection
    ld(EZ, 3, 32'h7FFF_0000);
    cfg(ONE, 0, ONE, ONE, 0, 8, 1, 3, 3); bus.jz_i = ONE;
    smp(32'h7FFF_FFFF, "t2_sample_sat");
    run(); wait_done(50, cyc);
    rd(EZ, 3, 32'h7FFF_FFFF, "t2_ez3_sat");
    // H update with unit chyez, probe outside the grid
    ld(EZ, 0, 0); ld(EZ, 1, ONE); ld(EZ, 2, 0); ld(EZ, 3, 0); ld(EZ, 5, 32'h0BAD_0000);
    for (int i = 0; i < 4; i++) ld(HY, 8'(i), 0);
    cfg(ONE, 0, ONE, ONE, ONE, 4, 1, 0, 5); bus.jz_i = 0;
    smp(0, "t3_probe_oob");
    run(); wait_done(50, cyc);
    chk("t3_latency", 32'(cyc), 9);
    rd(HY, 0, 32'h0001_0000, "t3_hy0"); rd(HY, 1, 32'hFFFF_0000, "t3_hy1");
    rd(HY, 2, 0, "t3_hy2"); rd(HY, 3, 0, "t3_hy3"); rd(EZ, 1, ONE, "t3_ez1");
    // source stall in WAIT_SRC, blocked load and busy readback
    cfg(ONE, 0, ONE, ONE, 0, 4, 2, 2, 2); bus.jz_i = ONE; bus.jz_valid_i = 0;
    smp(32'h0001_0000, "t4_s1"); smp(32'h0002_0000, "t4_s2");
    run();
    repeat (10) tick();
    chk("t4_stall_step_cnt", 32'(step_cnt_o), 0); chk("t4_jz_ready", 32'(bus.jz_ready_o), 1);
    chk("t4_busy", 32'(busy_o), 1);
    ld(EZ, 2, 32'h0000_7777);
    rd(EZ, 2, 0, "t4_rd_busy");
    bus.jz_valid_i = 1;
    wait_done(100, cyc);
    chk("t4_step_cnt", 32'(step_cnt_o), 2);
    rd(EZ, 2, 32'h0002_0000, "t4_ez2");
    // source index beyond the grid is skipped
    ld(EZ, 6, 32'h0000_5000);
    cfg(ONE, 0, ONE, ONE, 0, 4, 1, 6, 2);
    smp(32'h0002_0000, "t5_sample");
    run(); wait_done(50, cyc);
    rd(EZ, 6, 32'h0000_5000, "t5_ez6_untouched");
    // abort during the E sweep keeps the partial result
    for (int i = 0; i < 8; i++) begin ld(EZ, 8'(i), ONE); ld(HY, 8'(i), 0); end
    cfg(32'h0002_0000, 0, ONE, ONE, 0, 8, 1, 7, 7); bus.jz_i = 0; int_en_i = 1;
    run();
    repeat (10) tick();
    abort_i = 1; tick(); abort_i = 0;
    chk("t6_abort_idle", 32'(busy_o), 0);
    for (int i = 0; i < 3; i++) begin
      chk("t6_no_done", 32'(done_o), 0); chk("t6_no_int", 32'(int_o), 0);
      tick();
    end
    rd(EZ, 1, 32'h0002_0000, "t6_ez1"); rd(EZ, 2, 32'h0002_0000, "t6_ez2");
    rd(EZ, 3, ONE, "t6_ez3"); rd(EZ, 7, ONE, "t6_ez7");
    // degenerate starts finish at once
    int_en_i = 0;
    cfg(ONE, 0, ONE, ONE, 0, 1, 3, 0, 0);
    run();
    chk("t7_n1_done", 32'(done_o), 1); chk("t7_n1_busy", 32'(busy_o), 0);
    tick();
    chk("t7_n1_done_pulse", 32'(done_o), 0);
    cfg(ONE, 0, ONE, ONE, 0, 8, 0, 0, 0);
    run();
    chk("t7_s0_done", 32'(done_o), 1); chk("t7_s0_busy", 32'(busy_o), 0);
    tick();
    rd(EZ, 0, ONE, "t7_ez0"); rd(EZ, 1, 32'h0002_0000, "t7_ez1");
    repeat (3) tick();
    chk("rd_queue_drained", 32'(rd_exp.size()), 0);
    chk("sample_queue_drained", 32'(smp_exp.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fdtd_1d_engine.md
FDTD_1D_ENGINE -- requirements
Module: fdtd_1d_engine

Interface
REQ-001 Param DATA_W, default 32, signed fixed-point field/coefficient width.
REQ-002 Param FRAC_W, default 16, fraction bits of every DATA_W quantity.
REQ-003 Param MAX_CELLS, default 256, field depth; ADDR_W = clog2(MAX_CELLS).
REQ-004 Param STEP_W, default 16, time-step counter width.
REQ-005 ACLK  in  1  sole clock, rising edge.
REQ-006 ARESETn  in  1  asynchronous, active-low reset.
REQ-007 ceze_i, cezhy_i, cezj_i, chyh_i, chyez_i  in  DATA_W each  update coefficients, sampled at start.
REQ-008 n_cells_i  in  ADDR_W+1; n_steps_i  in  STEP_W; src_idx_i, probe_idx_i  in  ADDR_W  (sampled at start).
REQ-009 start_i  in  1  run request; abort_i  in  1  stop run.
REQ-010 jz_valid_i  in  1; jz_i  in  DATA_W; jz_ready_o  out  1  per-step source sample handshake.
REQ-011 ld_en_i  in  1; ld_sel_i  in  1 (0=Hy, 1=Ez); ld_addr_i  in  ADDR_W; ld_data_i  in  DATA_W  field load.
REQ-012 rd_en_i  in  1; rd_sel_i  in  1; rd_addr_i  in  ADDR_W; rd_data_o  out  DATA_W; rd_valid_o  out  1  readback.
REQ-013 busy_o  out  1; done_o  out  1 pulse; step_cnt_o  out  STEP_W.
REQ-014 sample_o  out  DATA_W; sample_valid_o  out  1  probe Ez after each step.
REQ-015 int_en_i  in  1; int_clr_i  in  1; int_o  out  1  level interrupt.

Function
REQ-016 FSM states IDLE, WAIT_SRC, UPD_H, UPD_E, INJECT, SAMPLE; start_i in IDLE latches config and enters WAIT_SRC.
REQ-017 start_i with n_cells_i<2 or n_steps_i==0: no field writes, done_o pulses next cycle, stay IDLE.
REQ-018 WAIT_SRC: jz_ready_o=1; on jz_valid_i&jz_ready_o capture jz_i, go UPD_H.
REQ-019 UPD_H: one cell per cycle, m=0..N-2: Hy[m] = chyh*Hy[m] + chyez*(Ez[m+1]-Ez[m]); N-1 cycles; Hy[N-1] unchanged.
REQ-020 UPD_E: m=1..N-1 per cycle: Ez[m] = ceze*Ez[m] + cezhy*(Hy[m]-Hy[m-1]), using this step's Hy; Ez[0] unchanged.
REQ-021 INJECT (1 cycle): Ez[src] += cezj*jz; skipped (no write) if src_idx>=N.
REQ-022 SAMPLE (1 cycle): sample_o=Ez[probe] and sample_valid_o=1 the following cycle; probe_idx>=N yields 0.
REQ-023 Step latency with jz_valid_i held high: 2N+1 cycles (WAIT_SRC 1, UPD_H N-1, UPD_E N-1, INJECT 1, SAMPLE 1).
REQ-024 step_cnt_o increments leaving SAMPLE; at n_steps go IDLE, done_o pulses 1 cycle, else WAIT_SRC.
REQ-025 Arithmetic: difference at DATA_W+1, products full precision, sum arithmetic-shifted right FRAC_W (truncate), saturated to signed DATA_W.
REQ-026 busy_o=1 in every state except IDLE; start_i while busy ignored.
REQ-027 ld_en_i writes only in IDLE; ignored while busy.
REQ-028 rd_en_i: rd_data_o/rd_valid_o one cycle later; while busy rd_valid_o=1 with rd_data_o=0.
REQ-029 abort_i (any busy state): IDLE next cycle, no done_o, no further writes; partial field contents retained.
REQ-030 int_o sets on done_o when int_en_i=1; int_clr_i clears; simultaneous set and clear: set wins.

Reset
REQ-031 ARESETn low: FSM IDLE; busy_o, done_o, jz_ready_o, rd_valid_o, sample_valid_o, int_o = 0; step_cnt_o, sample_o, rd_data_o = 0.
REQ-032 Field arrays are not reset; reset mid-run abandons the run with no done_o.

Structure
REQ-033 Package fdtd_pkg holds the FSM state enum, field-select constants (HY=0, EZ=1) and a saturating fixed-point multiply-accumulate function.
REQ-034 Sub-module fdtd_field_ram (one array per field, 1 write, 2 combinational read ports) instanced twice.

Verification
REQ-035 Unit coefficients (1.0=0x00010000), chyez=cezhy=0, cezj=1.0, jz=0x00008000, N=8, src=3, steps=4 -> Ez[3]=0x00020000, done_o at cycle 4*17 after start.
REQ-036 Ez[3]=0x7FFF0000, ceze=1.0, cezj=1.0, jz=0x00010000 -> Ez[3]=0x7FFFFFFF (saturation), sample_o matches.
REQ-037 N=4, chyh=1.0, chyez=1.0, Ez={0,0x10000,0,0}, Hy=0, jz=0, steps=1 -> Hy={0x10000,0xFFFF0000,0,0}.
REQ-038 jz_valid_i low 10 cycles in WAIT_SRC -> no field change, step_cnt_o frozen, resumes on valid.
REQ-039 abort_i mid UPD_E -> IDLE next cycle, no done_o/int_o; n_cells=1 start -> immediate done_o, fields untouched.
REQ-040 int_en=1, int_clr_i asserted on done cycle -> int_o=1; clear next cycle -> int_o=0.
